// File: rtl/rst_req_ctrl.sv
// Reset-request initiator: stretches a synchronous request into an active-low reset
// for a target domain, then handshakes on that domain's synchronized reset.
module rst_req_ctrl #(
    parameter int HOLD_CYCLES    = 16,
    parameter int SYNC_LEN       = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic arstn,
    input  logic req_i,
    input  logic ack_srst_i,
    output logic rst_n_o,
    output logic busy_o,
    output logic done_o,
    output logic timeout_o
);

    localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT   = '1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HOLD    = 3'd1;
    localparam logic [2:0] S_WAIT_HI = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [SYNC_LEN-1:0] sync_q;
    logic                ack_s;
    logic [2:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                timeout_q, timeout_d;
    logic                rst_n_q, rst_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_LEN-2:0], ack_srst_i};
    end

    assign ack_s = sync_q[SYNC_LEN-1];

    // Counter saturates rather than wrapping, so a stuck count can never re-arm a compare.
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_inc;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_i) begin
                    state_d   = S_HOLD;
                    timeout_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT_HI;
                    cnt_d   = '0;
                end
            end
            S_WAIT_HI: begin
                if (ack_s) begin
                    state_d = S_WAIT_LO;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!ack_s) begin
                    state_d = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they switch on the same edge as the state.
    assign rst_n_d = (state_d == S_IDLE) || (state_d == S_WAIT_LO) || (state_d == S_DONE);
    assign busy_d  = (state_d != S_IDLE);
    assign done_d  = (state_d == S_DONE);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            rst_n_q   <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            rst_n_q   <= rst_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rst_n_o   = rst_n_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rst_req_ctrl.sv
// Bench for rst_req_ctrl: directed table, hand sequences, then random requests
// and ack behaviour checked against a sequence-level timeline model.
`timescale 1ns/100ps
module tb_rst_req_ctrl;

    localparam int HOLD  = 16;
    localparam int SYNCN = 2;
    localparam int TMO   = 1024;

    logic clk = 1'b0, clk_b = 1'b0, arstn = 1'b1, req_i = 1'b0;
    logic ack_srst_i, rst_n_o, busy_o, done_o, timeout_o;
    logic [1:0] ack_mode = 2'd0;       // 0 target model, 1 tied 0, 2 tied 1, 3 random
    logic [2:0] tchain = 3'b111;
    logic ack_rnd = 1'b0;
    logic [SYNCN-1:0] ahist = '0;
    bit stop = 1'b0;
    int nchk = 0, nerr = 0, done_tot = 0;

    rst_req_ctrl #(.HOLD_CYCLES(HOLD), .SYNC_LEN(SYNCN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .arstn(arstn), .req_i(req_i), .ack_srst_i(ack_srst_i),
        .rst_n_o(rst_n_o), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;
    always #11.5 clk_b = ~clk_b;

    // Target domain: async-assert / sync-release reset synchronizer on clk_b.
    always @(posedge clk_b or negedge rst_n_o) begin
        if (!rst_n_o) tchain <= 3'b111;
        else          tchain <= {tchain[1:0], 1'b0};
    end
    always @(posedge clk_b) ack_rnd <= 1'($urandom_range(0, 1));
    assign ack_srst_i = (ack_mode == 2'd0) ? tchain[2] :
                        (ack_mode == 2'd1) ? 1'b0 :
                        (ack_mode == 2'd2) ? 1'b1 : ack_rnd;

    // Raw ack samples at each edge; the design acts on the one SYNCN edges old.
    always @(posedge clk) ahist <= {ahist[SYNCN-2:0], ack_srst_i};
    always @(posedge clk) if (done_o) done_tot++;

    task automatic chk1(input string name, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin nerr++; $display("FAIL %s: got %b expected %b", name, act, exp); end
    endtask
    task automatic chkn(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin nerr++; $display("FAIL %s: got %0d expected %0d", name, act, exp); end
    endtask
    task automatic chkv(input string name, input logic [3:0] act, input logic [3:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: {rst,busy,done,to} got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic run_until_idle(input int budget, output int lowc, output int donec,
                                  output bit hi_seen, output bit lo_seen, output bit ok);
        lowc = 0; donec = 0; hi_seen = 0; lo_seen = 0; ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!rst_n_o) lowc++;
            if (done_o) donec++;
            if (ack_srst_i) hi_seen = 1; else if (hi_seen) lo_seen = 1;
            if (!busy_o) begin ok = 1; break; end
        end
    endtask

    task automatic wait_wlo(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rst_n_o && busy_o && !done_o) begin ok = 1; break; end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_o) begin ok = 1; break; end
        end
    endtask

    task automatic mexp(input logic r, input logic b, input logic d, input logic t);
        @(negedge clk);
        chkv("model", {rst_n_o, busy_o, done_o, timeout_o}, {r, b, d, t});
    endtask

    // Timeline model: walks one sequence at a time from the rules, starting in IDLE at a negedge.
    task automatic model_run(input logic to_init);
        logic to, r, a;
        bit got;
        to = to_init;
        forever begin
            r = 1'b0;
            while (!r && !stop) begin
                @(posedge clk); r = req_i;
                if (!r) mexp(1'b1, 1'b0, 1'b0, to);
            end
            if (!r) break;
            to = 1'b0;
            mexp(1'b0, 1'b1, 1'b0, to);
            repeat (HOLD) begin @(posedge clk); mexp(1'b0, 1'b1, 1'b0, to); end
            got = 0;
            for (int n = 1; n <= TMO; n++) begin
                @(posedge clk); a = ahist[SYNCN-1];
                if (a) begin got = 1; break; end
                if (n < TMO) mexp(1'b0, 1'b1, 1'b0, to);
            end
            if (got) begin
                mexp(1'b1, 1'b1, 1'b0, to);
                got = 0;
                for (int n = 1; n <= TMO; n++) begin
                    @(posedge clk); a = ahist[SYNCN-1];
                    if (!a) begin got = 1; break; end
                    if (n < TMO) mexp(1'b1, 1'b1, 1'b0, to);
                end
                if (!got) to = 1'b1;
            end else begin
                to = 1'b1;
            end
            mexp(1'b1, 1'b1, 1'b1, to);
            @(posedge clk); mexp(1'b1, 1'b0, 1'b0, to);
        end
    endtask

    task automatic stim_run(input int ncyc);
        int k;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i % 256 == 0) begin
                k = $urandom_range(0, 9);
                ack_mode = (k < 6) ? 2'd0 : (k == 6) ? 2'd1 : (k == 7) ? 2'd2 : 2'd3;
            end
            req_i = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        req_i = 1'b0; ack_mode = 2'd0; stop = 1'b1;
    endtask

    typedef struct {
        logic       req;
        logic [1:0] mode;
        int         ncyc;
        logic       rst, busy, done, to;
    } vec_t;
    vec_t vt[13];

    initial begin
        int lowc, donec, d0;
        bit hi, lo, ok;

        // timeouts: ack tied low (WAIT_HI) then tied high (WAIT_LO)
        vt[0]  = '{1'b1, 2'd1, 1,    1'b0, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 2'd1, 16,   1'b0, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 2'd1, 1023, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 2'd1, 1,    1'b1, 1'b1, 1'b1, 1'b1};
        vt[4]  = '{1'b0, 2'd1, 1,    1'b1, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 2'd1, 5,    1'b1, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 2'd2, 1,    1'b0, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 2'd2, 16,   1'b0, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 2'd2, 1,    1'b1, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 2'd2, 1023, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[10] = '{1'b0, 2'd2, 1,    1'b1, 1'b1, 1'b1, 1'b1};
        vt[11] = '{1'b0, 2'd2, 1,    1'b1, 1'b0, 1'b0, 1'b1};
        vt[12] = '{1'b0, 2'd0, 10,   1'b1, 1'b0, 1'b0, 1'b1};

        // power-up sequence
        #1 arstn = 1'b0;
        repeat (5) @(negedge clk);
        chk1("rst_rst_n", rst_n_o, 1'b0);
        chk1("rst_busy", busy_o, 1'b1);
        chk1("rst_done", done_o, 1'b0);
        chk1("rst_timeout", timeout_o, 1'b0);
        arstn = 1'b1;
        run_until_idle(3000, lowc, donec, hi, lo, ok);
        chk1("pwr_idle", ok, 1'b1);
        chkn("pwr_low", lowc, HOLD);
        chkn("pwr_done", donec, 1);
        chk1("pwr_timeout", timeout_o, 1'b0);

        // single request with a responsive target
        req_i = 1'b1; @(negedge clk); req_i = 1'b0;
        chk1("req_rst_edge", rst_n_o, 1'b0);
        chk1("req_busy", busy_o, 1'b1);
        run_until_idle(3000, lowc, donec, hi, lo, ok);
        chk1("req_idle", ok, 1'b1);
        chkn("req_low", lowc + 1, HOLD + 1);
        chkn("req_done", donec, 1);
        chk1("req_ack_hi", hi, 1'b1);
        chk1("req_ack_lo", lo, 1'b1);
        chk1("req_rst_high", rst_n_o, 1'b1);

        for (int i = 0; i < 13; i++) begin
            req_i = vt[i].req; ack_mode = vt[i].mode;
            repeat (vt[i].ncyc) @(posedge clk);
            @(negedge clk);
            chkv($sformatf("vec%0d", i), {rst_n_o, busy_o, done_o, timeout_o},
                 {vt[i].rst, vt[i].busy, vt[i].done, vt[i].to});
        end
        req_i = 1'b0;

        // requests in HOLD and WAIT_LO are dropped
        d0 = done_tot;
        req_i = 1'b1; @(negedge clk); req_i = 1'b0;
        repeat (4) @(negedge clk);
        req_i = 1'b1; @(negedge clk); req_i = 1'b0;
        wait_wlo(ok);
        chk1("ign_wlo_reached", ok, 1'b1);
        req_i = 1'b1; @(negedge clk); req_i = 1'b0;
        run_until_idle(3000, lowc, donec, hi, lo, ok);
        chk1("ign_idle", ok, 1'b1);
        repeat (30) @(negedge clk);
        chkn("ign_one_done", done_tot - d0, 1);
        chk1("ign_stay_idle", busy_o, 1'b0);

        // held request: back-to-back with one IDLE cycle
        req_i = 1'b1;
        wait_done(ok);
        chk1("b2b_done1", ok, 1'b1);
        @(negedge clk);
        chk1("b2b_gap_idle", busy_o, 1'b0);
        @(negedge clk);
        chk1("b2b_restart_busy", busy_o, 1'b1);
        chk1("b2b_restart_rst", rst_n_o, 1'b0);
        wait_done(ok);
        chk1("b2b_done2", ok, 1'b1);
        req_i = 1'b0;
        run_until_idle(3000, lowc, donec, hi, lo, ok);
        chk1("b2b_idle", ok, 1'b1);

        // arstn in WAIT_LO
        req_i = 1'b1; @(negedge clk); req_i = 1'b0;
        wait_wlo(ok);
        chk1("ars_wlo_reached", ok, 1'b1);
        #2 arstn = 1'b0;
        #1;
        chk1("ars_rst_n", rst_n_o, 1'b0);
        chk1("ars_busy", busy_o, 1'b1);
        chk1("ars_done", done_o, 1'b0);
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        run_until_idle(3000, lowc, donec, hi, lo, ok);
        chk1("ars_idle", ok, 1'b1);
        chkn("ars_low", lowc, HOLD);
        chkn("ars_done_cnt", donec, 1);
        chk1("ars_timeout", timeout_o, 1'b0);

        // random requests and ack behaviour against the timeline model
        fork
            model_run(1'b0);
            stim_run(6000);
        join

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
